add_share_arb: RTL and testbench

- Round-robin scheduler that shares one fixed-latency W-bit adder (start/a/b in, y/valid out, 2-cycle latency, no backpressure) among N requesters.
- Accepts operand pairs through per-requester valid/ready handshakes and registers them onto the adder's input bus.
- Tracks the requester ID of every in-flight operation and steers each sum back to its originator.
- Provides enable/drain control and a sticky protocol-error flag for the shared-datapath subsystem.

---
 rtl/add_share_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 38 +++
 rtl/add_share_arb.sv | 149 ++++++++++++++
 tb/tb_add_share_arb.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/add_share_pkg.sv
// add_share_pkg
//   Shared types for the adder-sharing scheduler and its round-robin arbiter.
//   ID_W is sized for the largest supported requester count (8), so one tag
//   layout serves every legal N.
package add_share_pkg;

  localparam int unsigned N_MAX = 8;
  localparam int unsigned ID_W  = $clog2(N_MAX);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } arb_state_e;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin arbiter. The search begins one past the last
//   winner, so the previous winner has lowest priority next time.
// Ports:
//   req_i        N-bit request vector
//   ptr_i        index of the previous winner
//   grant_o      one-hot grant (zero when no request)
//   grant_idx_o  index of the granted requester
module rr_arbiter
  import add_share_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [N-1:0]    grant_o,
  output logic [ID_W-1:0] grant_idx_o
);

  int   idx;
  logic found;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr_i) + k) % N;
      if (!found && req_i[idx]) begin
        found          = 1'b1;
        grant_o[idx]   = 1'b1;
        grant_idx_o    = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/add_share_arb.sv
// add_share_arb
//   Shares one pipelined W-bit adder among N requesters. Grants one request
//   per cycle in round-robin order, registers the operands onto the adder
//   bus, tracks each in-flight operation's requester ID in a tag pipeline
//   and routes the sum back to its originator.
// Ports:
//   clk, rst              clock and async active-high reset
//   enable                1 = grant new requests, 0 = drain
//   req_valid/req_ready   per-requester handshake
//   req_a, req_b          packed operands, requester i at [i*W +: W]
//   resp_valid, resp_y    one-hot result pulse and its sum
//   add_start/a/b         adder input bus
//   add_y, add_valid      adder result
//   busy                  work issued, in flight or being returned
//   err                   sticky: add_valid disagreed with the head tag
module add_share_arb
  import add_share_pkg::*;
#(
  parameter int N   = 4,
  parameter int W   = 20,
  parameter int LAT = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  output logic [N-1:0]   resp_valid,
  output logic [W-1:0]   resp_y,
  output logic           add_start,
  output logic [W-1:0]   add_a,
  output logic [W-1:0]   add_b,
  input  logic [W-1:0]   add_y,
  input  logic           add_valid,
  output logic           busy,
  output logic           err
);

  arb_state_e      state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q;
  logic [ID_W-1:0] issue_id_q;
  logic [ID_W-1:0] win_idx;
  logic [N-1:0]    win;
  logic            accept;
  logic            start_q;
  logic [W-1:0]    a_q, b_q, y_q;
  logic [N-1:0]    resp_q;
  logic            err_q;
  tag_t            tag_q [LAT];
  tag_t            head;
  logic            tags_vld;
  logic            pipe_empty;

  rr_arbiter #(.N(N)) u_arb (
    .req_i       (req_valid),
    .ptr_i       (rr_ptr_q),
    .grant_o     (win),
    .grant_idx_o (win_idx)
  );

  assign req_ready = (enable && (state_q != DRAIN)) ? win : '0;
  assign accept    = |req_ready;

  // The last tag stage lines up with add_valid from the adder.
  assign head = tag_q[LAT-1];

  always_comb begin
    tags_vld = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      tags_vld = tags_vld | tag_q[i].vld;
    end
  end

  assign pipe_empty = !start_q && !tags_vld;

  // The tag enters stage 0 on the edge where the adder samples add_start,
  // so stage LAT-1 is occupied exactly while that sum is on add_y.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q   <= ID_W'(N-1);
      issue_id_q <= '0;
      start_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      resp_q     <= '0;
      y_q        <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      start_q <= accept;
      if (accept) begin
        rr_ptr_q   <= win_idx;
        issue_id_q <= win_idx;
        a_q        <= req_a[int'(win_idx)*W +: W];
        b_q        <= req_b[int'(win_idx)*W +: W];
      end
      tag_q[0] <= '{vld: start_q, id: issue_id_q};
      for (int i = 1; i < LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
      if (add_valid && head.vld) begin
        resp_q <= N'(1) << head.id;
        y_q    <= add_y;
      end else begin
        resp_q <= '0;
      end
      if (add_valid != head.vld) begin
        err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable && |req_valid) state_d = RUN;
      RUN: begin
        if (!enable) begin
          state_d = DRAIN;
        end else if (!(|req_valid) && pipe_empty) begin
          state_d = IDLE;
        end
      end
      DRAIN:   if (pipe_empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign add_start  = start_q;
  assign add_a      = a_q;
  assign add_b      = b_q;
  assign resp_valid = resp_q;
  assign resp_y     = y_q;
  assign err        = err_q;
  assign busy       = start_q | tags_vld | (|resp_q);

endmodule

// File: tb/tb_add_share_arb.sv
// tb_add_share_arb
//   Directed bench for add_share_arb with a 2-cycle pipelined adder model
//   that is reset together with the scheduler.
module tb_add_share_arb;
  import add_share_pkg::*;

  localparam int N = 4;
  localparam int W = 20;
  localparam int LAT = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           enable;
  logic [N-1:0]   req_valid, req_ready, resp_valid;
  logic [N*W-1:0] req_a, req_b;
  logic [W-1:0]   resp_y, add_a, add_b, add_y;
  logic           add_start, add_valid, busy, err;

  int vectors = 0;
  int miscompares = 0;

  logic         forceValid;
  logic         s1v, s2v;
  logic [W-1:0] s1y, s2y;

  add_share_arb #(.N(N), .W(W), .LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_y     (resp_y),
    .add_start  (add_start),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_y      (add_y),
    .add_valid  (add_valid),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Two-stage adder model: start sampled at one edge, valid two cycles later.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s1v <= 1'b0; s2v <= 1'b0; s1y <= '0; s2y <= '0;
    end else begin
      s1v <= add_start;
      s1y <= add_a + add_b;
      s2v <= s1v;
      s2y <= s1y;
    end
  end

  assign add_valid = s2v | forceValid;
  assign add_y     = s2y;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic [N-1:0] v);
    enable    = en;
    req_valid = v;
  endtask

  task automatic setOperands(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[idx*W +: W] = a;
    req_b[idx*W +: W] = b;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulseReset;
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; req_valid = '0; req_a = '0; req_b = '0; forceValid = 1'b0;
    #3;
    checkOutput("rstStart", 32'(add_start), 0);
    checkOutput("rstA", 32'(add_a), 0);
    checkOutput("rstB", 32'(add_b), 0);
    checkOutput("rstResp", 32'(resp_valid), 0);
    checkOutput("rstY", 32'(resp_y), 0);
    checkOutput("rstErr", 32'(err), 0);
    checkOutput("rstBusy", 32'(busy), 0);
    @(posedge clk); #1; rst = 1'b0;
    cyc;

    // Single request from requester 0
    setOperands(0, 20'h00005, 20'h00003);
    applyStimulus(1'b1, 4'b0001); #1;
    checkOutput("singleReady", 32'(req_ready), 32'b0001);
    cyc; applyStimulus(1'b1, 4'b0000); #1;
    checkOutput("singleStart", 32'(add_start), 1);
    checkOutput("singleAddA", 32'(add_a), 32'h5);
    checkOutput("singleAddB", 32'(add_b), 32'h3);
    checkOutput("singleEarlyResp", 32'(resp_valid), 0);
    cyc; cyc; cyc; #1;
    checkOutput("singleResp", 32'(resp_valid), 32'b0001);
    checkOutput("singleY", 32'(resp_y), 32'h8);
    checkOutput("singleBusy", 32'(busy), 1);
    cyc; #1;
    checkOutput("singleRespEnd", 32'(resp_valid), 0);
    checkOutput("singleBusyEnd", 32'(busy), 0);

    // All four requesting continuously after a fresh reset
    pulseReset;
    cyc;
    for (int i = 0; i < N; i++) setOperands(i, W'(i), 20'h00010);
    for (int k = 0; k <= 10; k++) begin
      applyStimulus(1'b1, (k < 6) ? 4'b1111 : 4'b0000); #1;
      checkOutput("rrGrant", 32'(req_ready), (k < 6) ? (32'd1 << (k % 4)) : 32'd0);
      if (k >= 4) begin
        if (k - 4 < 6) begin
          checkOutput("rrResp", 32'(resp_valid), 32'd1 << ((k - 4) % 4));
          checkOutput("rrY", 32'(resp_y), 32'h10 + 32'((k - 4) % 4));
        end else begin
          checkOutput("rrRespIdle", 32'(resp_valid), 0);
        end
      end
      cyc;
    end
    checkOutput("rrErr", 32'(err), 0);

    // Overflow wraps modulo 2^W
    setOperands(2, 20'hFFFFF, 20'h00002);
    applyStimulus(1'b1, 4'b0100); #1;
    checkOutput("ovfReady", 32'(req_ready), 32'b0100);
    cyc; applyStimulus(1'b1, 4'b0000);
    cyc; cyc; cyc; #1;
    checkOutput("ovfResp", 32'(resp_valid), 32'b0100);
    checkOutput("ovfY", 32'(resp_y), 32'h1);
    cyc; cyc;

    // Drain with two operations in flight
    setOperands(3, 20'h00007, 20'h00001);
    setOperands(0, 20'h00100, 20'h00023);
    applyStimulus(1'b1, 4'b1001); #1;
    checkOutput("drainGrant0", 32'(req_ready), 32'b1000);
    cyc; #1;
    checkOutput("drainGrant1", 32'(req_ready), 32'b0001);
    cyc; applyStimulus(1'b0, 4'b1111); #1;
    checkOutput("drainNoGrantA", 32'(req_ready), 0);
    cyc; #1;
    checkOutput("drainNoGrantB", 32'(req_ready), 0);
    checkOutput("drainState", 32'(dut.state_q), 32'(DRAIN));
    cyc; #1;
    checkOutput("drainResp0", 32'(resp_valid), 32'b1000);
    checkOutput("drainY0", 32'(resp_y), 32'h8);
    checkOutput("drainNoGrantC", 32'(req_ready), 0);
    cyc; #1;
    checkOutput("drainResp1", 32'(resp_valid), 32'b0001);
    checkOutput("drainY1", 32'(resp_y), 32'h123);
    cyc; #1;
    checkOutput("drainIdle", 32'(dut.state_q), 32'(IDLE));
    checkOutput("drainBusy", 32'(busy), 0);
    checkOutput("drainNoGrantD", 32'(req_ready), 0);
    applyStimulus(1'b1, 4'b0000);
    cyc;

    // Protocol error: add_valid with an empty tag pipeline
    forceValid = 1'b1;
    cyc; forceValid = 1'b0; #1;
    checkOutput("errSet", 32'(err), 1);
    checkOutput("errNoResp", 32'(resp_valid), 0);
    cyc; #1;
    checkOutput("errSticky", 32'(err), 1);
    checkOutput("errNoResp2", 32'(resp_valid), 0);
    pulseReset; #1;
    checkOutput("errCleared", 32'(err), 0);
    cyc;

    // Reset in the middle of an operation
    setOperands(0, 20'h00001, 20'h00001);
    applyStimulus(1'b1, 4'b0001); #1;
    checkOutput("midReady", 32'(req_ready), 32'b0001);
    cyc; applyStimulus(1'b1, 4'b0000);
    cyc; rst = 1'b1; #1;
    checkOutput("midStart", 32'(add_start), 0);
    checkOutput("midAddA", 32'(add_a), 0);
    checkOutput("midResp", 32'(resp_valid), 0);
    checkOutput("midBusy", 32'(busy), 0);
    cyc; rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      #1;
      checkOutput("midNoStaleResp", 32'(resp_valid), 0);
      checkOutput("midNoErr", 32'(err), 0);
      cyc;
    end
    applyStimulus(1'b1, 4'b1111); #1;
    checkOutput("midPriority", 32'(req_ready), 32'b0001);
    applyStimulus(1'b1, 4'b0000);
    cyc;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
